// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - LEGv8 5-stage hazard, forwarding and flush controller
module pipe_hazard_ctrl #(
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rn,
  input  logic [$clog2(NREG)-1:0] id_rm,
  input  logic                    id_uses_rn,
  input  logic                    id_uses_rm,
  input  logic [$clog2(NREG)-1:0] id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_is_load,
  input  logic                    id_set_flags,
  input  logic                    id_uses_flags,
  input  logic                    ex_br_taken,
  output logic                    stall,
  output logic                    flush,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int            RW = $clog2(NREG);
  localparam logic [RW-1:0] ZR = RW'(ZERO_REG);

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic          uses_rn;
    logic          uses_rm;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          is_load;
    logic          set_flags;
  } stage_t;

  stage_t           r_ex;
  stage_t           r_mem;
  stage_t           r_wb;
  stage_t           w_id;
  logic             w_load_use;
  logic             w_flag_haz;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_unused_ok;

  // True when the ID source r is produced by the valid writer sitting in EX
  function automatic logic src_hit(input logic [RW-1:0] r, input logic use_r, input stage_t ex);
    src_hit = use_r && (r != ZR) && ex.v && ex.reg_write && (ex.rd == r);
  endfunction

  // MEM result wins over WB; a load in MEM has no data yet, so it never forwards
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src, input logic use_src,
                                         input stage_t mem, input stage_t wb);
    fwd_sel = 2'b00;
    if (use_src && (src != ZR)) begin
      if (mem.v && mem.reg_write && !mem.is_load && (mem.rd == src))
        fwd_sel = 2'b10;
      else if (wb.v && wb.reg_write && (wb.rd == src))
        fwd_sel = 2'b01;
    end
  endfunction

  // Hazard detection; a taken branch squashes ID anyway, so flush masks stall
  always_comb begin
    w_load_use = id_valid && r_ex.is_load &&
                 (src_hit(id_rn, id_uses_rn, r_ex) || src_hit(id_rm, id_uses_rm, r_ex));
    w_flag_haz = id_valid && id_uses_flags && r_ex.v && r_ex.set_flags;
    flush      = ex_br_taken && r_ex.v;
    stall      = (w_load_use || w_flag_haz) && !flush;
  end

  // Operand selects for the instruction currently in EX
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (r_ex.v) begin
      fwd_a = fwd_sel(r_ex.rn, r_ex.uses_rn, r_mem, r_wb);
      fwd_b = fwd_sel(r_ex.rm, r_ex.uses_rm, r_mem, r_wb);
    end
  end

  // Next EX contents: ID fields, turned into a bubble on stall or flush
  always_comb begin
    w_id.v         = id_valid && !stall && !flush;
    w_id.rn        = id_rn;
    w_id.rm        = id_rm;
    w_id.uses_rn   = id_uses_rn;
    w_id.uses_rm   = id_uses_rm;
    w_id.rd        = id_rd;
    w_id.reg_write = id_reg_write;
    w_id.is_load   = id_is_load;
    w_id.set_flags = id_set_flags;
  end

  // Shadow pipeline advance; older stages always move, the branch keeps its v into MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id;
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // WB only needs v/rd/reg_write; the remaining shadow fields ride along unused
  assign w_unused_ok = ^{r_mem, r_wb};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rn, id_uses_rm, id_reg_write;
  logic       id_is_load, id_set_flags, id_uses_flags, ex_br_taken;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       stall, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(.NREG(32), .ZERO_REG(31), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_set_flags(id_set_flags), .id_uses_flags(id_uses_flags),
    .ex_br_taken(ex_br_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic id_set(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic sf, input logic uf);
    id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; id_set_flags = sf; id_uses_flags = uf;
    #1;
  endtask

  task automatic idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    ex_br_taken = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0;
    ex_br_taken = 1'b0;
    idle();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    reset = 1'b1;
    tick();

    // 1: LDUR X2,[X1] ; ADDS X3,X2,X4
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    chk("t1_ld_nostall", stall, 0);
    tick();
    id_set(1, 2, 4, 1, 1, 3, 1, 0, 1, 0);
    chk("t1_stall", stall, 1);
    chk("t1_noflush", flush, 0);
    tick();
    id_set(1, 2, 4, 1, 1, 3, 1, 0, 1, 0);
    chk("t1_stall_1cyc", stall, 0);
    chk("t1_bubble_fwd", fwd_a, 0);
    chk("t1_scnt", stall_cnt, 1);
    tick();
    idle();
    chk("t1_fwd_a_wb", fwd_a, 2'b01);
    chk("t1_fwd_b", fwd_b, 2'b00);
    drain();

    // 2: ADDS X5,X1,X1 ; SUBS X6,X5,X5 ; ADDI X7,X5,#1
    id_set(1, 1, 1, 1, 1, 5, 1, 0, 1, 0);
    tick();
    id_set(1, 5, 5, 1, 1, 6, 1, 0, 1, 0);
    chk("t2_nostall_a", stall, 0);
    tick();
    id_set(1, 5, 0, 1, 0, 7, 1, 0, 0, 0);
    chk("t2_subs_fwd_a", fwd_a, 2'b10);
    chk("t2_subs_fwd_b", fwd_b, 2'b10);
    chk("t2_nostall_b", stall, 0);
    tick();
    idle();
    chk("t2_addi_fwd_a", fwd_a, 2'b01);
    chk("t2_addi_fwd_b", fwd_b, 2'b00);
    drain();

    // 3: ADDI X31,X0,#3 ; ADDS X8,X31,X31, then LDUR X31 ; use X31
    id_set(1, 0, 0, 1, 0, 31, 1, 0, 0, 0);
    tick();
    id_set(1, 31, 31, 1, 1, 8, 1, 0, 1, 0);
    chk("t3_nostall", stall, 0);
    tick();
    idle();
    chk("t3_fwd_a_zr", fwd_a, 0);
    chk("t3_fwd_b_zr", fwd_b, 0);
    drain();
    id_set(1, 1, 0, 1, 0, 31, 1, 1, 0, 0);
    tick();
    id_set(1, 31, 0, 1, 0, 9, 1, 0, 0, 0);
    chk("t3_ld_zr_nostall", stall, 0);
    drain();

    // 4: SUBS X1,X2,X3 ; B.LT taken ; wrong-path SUBS squashed
    id_set(1, 2, 3, 1, 1, 1, 1, 0, 1, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_flag_stall", stall, 1);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_flag_1cyc", stall, 0);
    chk("t4_scnt", stall_cnt, 2);
    tick();
    ex_br_taken = 1'b1;
    id_set(1, 1, 1, 1, 1, 9, 1, 0, 1, 0);
    chk("t4_flush", flush, 1);
    chk("t4_flush_nostall", stall, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_ex_squashed", flush, 0);
    chk("t4_no_flag_from_squash", stall, 0);
    chk("t4_fcnt", flush_cnt, 1);
    drain();

    // 5: load in EX, branch taken, ID reads load rd
    id_set(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
    tick();
    ex_br_taken = 1'b1;
    id_set(1, 4, 0, 1, 0, 5, 1, 0, 0, 0);
    chk("t5_flush", flush, 1);
    chk("t5_stall_masked", stall, 0);
    tick();
    ex_br_taken = 1'b0;
    idle();
    chk("t5_scnt", stall_cnt, 2);
    chk("t5_fcnt", flush_cnt, 2);
    drain();

    // 6: 20 load-use pairs, stall_cnt saturates at 15
    for (int i = 0; i < 20; i++) begin
      id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      tick();
      id_set(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
      tick();
    end
    chk("t6_sat", stall_cnt, 15);
    id_set(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
    tick();
    id_set(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
    chk("t6_stall_pre_rst", stall, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_fwd_a", fwd_a, 0);
    chk("t6_rst_fwd_b", fwd_b, 0);
    chk("t6_rst_scnt", stall_cnt, 0);
    chk("t6_rst_fcnt", flush_cnt, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_post_rst_empty", stall, 0);
    tick();
    chk("t6_post_rst_scnt", stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
